sitcpxg_tx_arbiter: RTL

//  Shares the single SiTCPXG 64-bit TX stream between NUM_SRC data sources (test generator, loopback, user DAQ...).

---
 rtl/sitcpxg_pkg.sv | 12 +
 rtl/sitcpxg_tx_arbiter_rr_pick.sv | 27 ++
 rtl/sitcpxg_tx_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sitcpxg_pkg.sv
// Shared types and constants for the SiTCPXG TX arbiter.
package sitcpxg_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam logic [3:0] TXB_IDLE = 4'd0;
    localparam logic [3:0] TXB_FULL = 4'd8;
    localparam int         BUDGET_W = 17;
endpackage

// File: rtl/sitcpxg_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester strictly after i_ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_any
);
    logic [PW-1:0] w_idx;

    // Scan from farthest to nearest so the nearest requester after i_ptr wins.
    always_comb begin
        o_gnt = '0;
        w_idx = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
            end
        end
    end

    assign o_any = |i_req;
endmodule

// File: rtl/sitcpxg_tx_arbiter.sv
// Round-robin arbiter sharing the SiTCPXG 64-bit TX stream between NUM_SRC sources,
// with a per-grant byte quantum, AFULL back-pressure and session gating.
module sitcpxg_tx_arbiter
    import sitcpxg_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int QUANTUM = 1024
) (
    input  logic                   CLK156M,
    input  logic                   RSTn,
    input  logic                   SiTCPXG_ESTABLISHED,
    input  logic                   SiTCPXG_TX_AFULL,
    output logic [63:0]            SiTCPXG_TX_D,
    output logic [3:0]             SiTCPXG_TX_B,
    input  logic [NUM_SRC-1:0]     SRC_EN,
    input  logic [NUM_SRC-1:0]     SRC_REQ,
    input  logic [NUM_SRC-1:0]     SRC_VLD,
    input  logic [NUM_SRC-1:0]     SRC_LAST,
    input  logic [64*NUM_SRC-1:0]  SRC_D,
    input  logic [4*NUM_SRC-1:0]   SRC_B,
    output logic [NUM_SRC-1:0]     SRC_RDY,
    output logic [NUM_SRC-1:0]     SRC_GNT,
    output logic                   BUSY
);
    localparam int                  PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [BUDGET_W-1:0] QBUDGET = BUDGET_W'(QUANTUM);

    arb_state_e          r_state;
    logic                r_est;
    logic                r_afull;
    logic [NUM_SRC-1:0]  r_gnt;
    logic [PW-1:0]       r_ptr;
    logic [BUDGET_W-1:0] r_budget;
    logic [63:0]         r_tx_d;
    logic [3:0]          r_tx_b;

    logic [NUM_SRC-1:0]  w_req;
    logic [NUM_SRC-1:0]  w_pick;
    logic                w_any;
    logic [63:0]         w_d;
    logic [3:0]          w_b;
    logic                w_vld;
    logic                w_last;
    logic [PW-1:0]       w_gidx;
    logic                w_req_g;
    logic                w_rdy;
    logic                w_acc;
    logic [BUDGET_W-1:0] w_budget_nxt;
    logic                w_exit;

    assign w_req = SRC_REQ & SRC_EN;

    rr_pick #(.N(NUM_SRC), .PW(PW)) u_pick (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick),
        .o_any (w_any)
    );

    // AND-OR mux of the owner's beat; r_gnt is one-hot or zero.
    always_comb begin
        w_d    = '0;
        w_b    = '0;
        w_vld  = 1'b0;
        w_last = 1'b0;
        w_gidx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_d    = w_d | (SRC_D[64*i +: 64] & {64{r_gnt[i]}});
            w_b    = w_b | (SRC_B[4*i +: 4] & {4{r_gnt[i]}});
            w_vld  = w_vld | (SRC_VLD[i] & r_gnt[i]);
            w_last = w_last | (SRC_LAST[i] & r_gnt[i]);
            if (r_gnt[i]) w_gidx = PW'(i);
        end
    end

    assign w_req_g      = |(w_req & r_gnt);
    assign w_rdy        = (r_state == GRANT) & r_est & ~r_afull;
    assign w_acc        = w_rdy & w_vld;
    // An oversize beat is taken whole; the budget floors at zero.
    assign w_budget_nxt = (BUDGET_W'(w_b) > r_budget) ? '0 : r_budget - BUDGET_W'(w_b);
    assign w_exit       = w_acc ? (w_last | (w_budget_nxt < BUDGET_W'(TXB_FULL))) : ~w_req_g;

    always_ff @(posedge CLK156M or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= IDLE;
            r_est    <= 1'b0;
            r_afull  <= 1'b0;
            r_gnt    <= '0;
            r_ptr    <= PW'(NUM_SRC - 1);
            r_budget <= '0;
            r_tx_d   <= '0;
            r_tx_b   <= TXB_IDLE;
        end else begin
            r_est   <= SiTCPXG_ESTABLISHED;
            r_afull <= SiTCPXG_TX_AFULL;
            r_tx_b  <= TXB_IDLE;
            // Zero-byte beats are swallowed: handshaked but never forwarded.
            if (w_acc && (w_b != TXB_IDLE)) begin
                r_tx_b <= w_b;
                r_tx_d <= w_d;
            end
            case (r_state)
                IDLE: begin
                    if (r_est && w_any) begin
                        r_gnt    <= w_pick;
                        r_budget <= QBUDGET;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (!r_est) begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        if (w_acc) r_budget <= w_budget_nxt;
                        if (w_exit) begin
                            r_gnt   <= '0;
                            r_ptr   <= w_gidx;
                            r_state <= GAP;
                        end
                    end
                end
                GAP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign SiTCPXG_TX_D = r_tx_d;
    assign SiTCPXG_TX_B = r_tx_b;
    assign SRC_RDY      = r_gnt & {NUM_SRC{w_rdy}};
    assign SRC_GNT      = r_gnt;
    assign BUSY         = (r_state != IDLE);
endmodule
